// File: rtl/serial_adder.sv
// Bit-serial adder: loads two operands on start, adds LSB-first over WIDTH
// clocks through one full-adder slice and a carry flop, then pulses done.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             bit_s;
    logic             carry_nxt;

    // Single full-adder slice built from the two half-adder stages.
    assign bit_s     = a_sr[0] ^ b_sr[0] ^ carry;
    assign carry_nxt = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
    assign last      = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last)  state_nxt = S_FIN;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= 1'b0;
                        cnt   <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                    end
                end
                S_RUN: begin
                    // Sum fills from the MSB so bit 0 lands in place after WIDTH shifts.
                    sum   <= {bit_s, sum[WIDTH-1:1]};
                    a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
                    carry <= carry_nxt;
                    cnt   <= cnt + CW'(1);
                    if (last) cout <= carry_nxt;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_FIN);
endmodule
